// File: rtl/uart_tx_write_arbiter.sv
// uart_tx_write_arbiter
// Shares one UART transmitter between two bus-side write requesters. Each
// requester's level write strobe is edge-detected, its byte is parked in a
// one-deep holding register, and a round-robin FSM issues one tx_start pulse
// per accepted byte while tracking the transmitter's busy handshake.
module uart_tx_write_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr0,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic                  wr1,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  grant_id,
  output logic                  pend0,
  output logic                  pend1,
  output logic                  ovf0,
  output logic                  ovf1,
  output logic                  err_timeout
);

  localparam int CNT_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t                  r_state;
  logic                    r_last_wr0;
  logic                    r_last_wr1;
  logic [DATA_WIDTH-1:0]   r_hold0;
  logic [DATA_WIDTH-1:0]   r_hold1;
  logic                    r_pend0;
  logic                    r_pend1;
  logic                    r_ovf0;
  logic                    r_ovf1;
  logic                    r_err;
  logic                    r_rr;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_tx_start;
  logic [DATA_WIDTH-1:0]   r_tx_data;
  logic                    r_grant;

  logic                    w_ev0;
  logic                    w_ev1;
  logic                    w_grant_go;
  logic                    w_sel;
  logic                    w_take0;
  logic                    w_take1;

  // A held strobe yields a single event on its rising edge.
  assign w_ev0 = wr0 & ~r_last_wr0;
  assign w_ev1 = wr1 & ~r_last_wr1;

  // Grant only from IDLE with the transmitter free; on a tie the requester
  // that did not win last time goes next.
  assign w_grant_go = (r_state == S_IDLE) && !tx_busy && (r_pend0 || r_pend1);
  assign w_sel      = (r_pend0 && r_pend1) ? ~r_rr : r_pend1;
  assign w_take0    = w_grant_go && !w_sel;
  assign w_take1    = w_grant_go &&  w_sel;

  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign grant_id    = r_grant;
  assign pend0       = r_pend0;
  assign pend1       = r_pend1;
  assign ovf0        = r_ovf0;
  assign ovf1        = r_ovf1;
  assign err_timeout = r_err;

  // Remember previous strobe levels for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_wr0 <= 1'b0;
      r_last_wr1 <= 1'b0;
    end else begin
      r_last_wr0 <= wr0;
      r_last_wr1 <= wr1;
    end
  end

  // Holding registers: load when the slot is free or being emptied this cycle.
  always_ff @(posedge clk) begin
    if (w_ev0 && (!r_pend0 || w_take0)) r_hold0 <= data0;
    if (w_ev1 && (!r_pend1 || w_take1)) r_hold1 <= data1;
  end

  // Occupancy and sticky overflow flags; a new accept beats the take-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend0 <= 1'b0;
      r_pend1 <= 1'b0;
      r_ovf0  <= 1'b0;
      r_ovf1  <= 1'b0;
    end else begin
      if (w_ev0) begin
        if (!r_pend0 || w_take0) r_pend0 <= 1'b1;
        else                     r_ovf0  <= 1'b1;
      end else if (w_take0) begin
        r_pend0 <= 1'b0;
      end
      if (w_ev1) begin
        if (!r_pend1 || w_take1) r_pend1 <= 1'b1;
        else                     r_ovf1  <= 1'b1;
      end else if (w_take1) begin
        r_pend1 <= 1'b0;
      end
    end
  end

  // Arbitration FSM with registered start pulse, data, grant and timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rr       <= 1'b1;
      r_cnt      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_grant    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_go) begin
            r_tx_data  <= w_sel ? r_hold1 : r_hold0;
            r_grant    <= w_sel;
            r_rr       <= w_sel;
            r_tx_start <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == CNT_LAST) begin
            // Transmitter never acknowledged: the byte is abandoned.
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_write_arbiter.sv
// Scoreboard bench for uart_tx_write_arbiter: stimulus pushes each expected
// {grant_id, tx_data} pair; a monitor pops one on every tx_start pulse.
module tb_uart_tx_write_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr0, wr1;
  logic [7:0] data0, data1;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       grant_id, pend0, pend1, ovf0, ovf1, err_timeout;

  logic       force_busy = 1'b0;
  logic       model_en   = 1'b1;
  int         frame_len  = 3;
  int         mcnt       = 0;

  int         n_vec  = 0;
  int         n_fail = 0;
  int         n_starts = 0;
  logic [8:0] expq[$];

  always #5 clk = ~clk;

  uart_tx_write_arbiter #(.DATA_WIDTH(8), .BUSY_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .wr0(wr0), .data0(data0), .wr1(wr1), .data1(data1),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .grant_id(grant_id), .pend0(pend0), .pend1(pend1),
    .ovf0(ovf0), .ovf1(ovf1), .err_timeout(err_timeout)
  );

  // TX core model: busy for frame_len clocks starting the clock after tx_start.
  always @(posedge clk) begin
    if (tx_start && model_en) mcnt <= frame_len;
    else if (mcnt > 0)        mcnt <= mcnt - 1;
  end
  assign tx_busy = force_busy | (mcnt != 0);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every start pulse must match the oldest expected transfer.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      logic [8:0] e;
      n_starts++;
      if (expq.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_tx_start: got grant=%0d data=%0h, expected none", grant_id, tx_data);
      end else begin
        e = expq.pop_front();
        check("tx_grant", {31'd0, grant_id}, {31'd0, e[8]});
        check("tx_data", {24'd0, tx_data}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr0 = 1'b0; wr1 = 1'b0; force_busy = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 500; k++) begin
      if (expq.size() == 0 && !tx_busy && !tx_start) break;
      tick();
    end
    if (k == 500) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending transfers, expected 0", nm, expq.size());
      expq.delete();
    end
    repeat (4) tick();
  endtask

  task automatic pulse0(input logic [7:0] d);
    wr0 = 1'b1; data0 = d; tick(); wr0 = 1'b0; tick();
  endtask

  initial begin
    int s0;
    reset = 1'b1; wr0 = 1'b0; wr1 = 1'b0; data0 = '0; data1 = '0;
    do_reset();

    // Reset state
    check("rst_tx_start", {31'd0, tx_start}, 0);
    check("rst_tx_data", {24'd0, tx_data}, 0);
    check("rst_grant", {31'd0, grant_id}, 0);
    check("rst_pend", {30'd0, pend1, pend0}, 0);
    check("rst_ovf", {30'd0, ovf1, ovf0}, 0);
    check("rst_err", {31'd0, err_timeout}, 0);

    // T1: single write, held 5 clocks
    frame_len = 3;
    s0 = n_starts;
    wr0 = 1'b1; data0 = 8'hA5; expq.push_back({1'b0, 8'hA5});
    tick();
    check("t1_pend0_set", {31'd0, pend0}, 1);
    check("t1_start_early", {31'd0, tx_start}, 0);
    tick();
    check("t1_start", {31'd0, tx_start}, 1);
    check("t1_pend0_clr", {31'd0, pend0}, 0);
    tick();
    check("t1_start_1cyc", {31'd0, tx_start}, 0);
    tick(); tick();
    wr0 = 1'b0;
    wait_idle("t1");
    check("t1_start_count", n_starts - s0, 1);

    // T2: simultaneous rises, twice; requester 0 wins both ties
    do_reset();
    frame_len = 10;
    for (int r = 0; r < 2; r++) begin
      wr0 = 1'b1; wr1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
      expq.push_back({1'b0, 8'h11});
      expq.push_back({1'b1, 8'h22});
      tick();
      check("t2_both_pend", {30'd0, pend1, pend0}, 3);
      wr0 = 1'b0; wr1 = 1'b0;
      wait_idle("t2");
    end

    // T3: overflow while transmitter busy; held byte still sent
    do_reset();
    frame_len = 3;
    force_busy = 1'b1;
    expq.push_back({1'b0, 8'h01});
    pulse0(8'h01);
    pulse0(8'h02);
    pulse0(8'h03);
    check("t3_ovf0", {31'd0, ovf0}, 1);
    check("t3_pend0", {31'd0, pend0}, 1);
    check("t3_ovf1", {31'd0, ovf1}, 0);
    repeat (44) tick();
    check("t3_no_start", {31'd0, tx_start}, 0);
    force_busy = 1'b0;
    wait_idle("t3");
    check("t3_pend0_done", {31'd0, pend0}, 0);
    check("t3_ovf0_sticky", {31'd0, ovf0}, 1);

    // T4: accept on the very clock requester 1 is taken
    do_reset();
    force_busy = 1'b1;
    expq.push_back({1'b1, 8'h55});
    expq.push_back({1'b1, 8'h7E});
    wr1 = 1'b1; data1 = 8'h55; tick();
    wr1 = 1'b0; tick();
    force_busy = 1'b0; wr1 = 1'b1; data1 = 8'h7E;
    tick();
    check("t4_start", {31'd0, tx_start}, 1);
    check("t4_pend1", {31'd0, pend1}, 1);
    check("t4_ovf1", {31'd0, ovf1}, 0);
    wr1 = 1'b0;
    wait_idle("t4");
    check("t4_pend1_done", {31'd0, pend1}, 0);

    // T5: busy never rises; timeout after the start cycle plus four wait clocks
    do_reset();
    model_en = 1'b0;
    wr0 = 1'b1; wr1 = 1'b1; data0 = 8'h3C; data1 = 8'h4D;
    expq.push_back({1'b0, 8'h3C});
    expq.push_back({1'b1, 8'h4D});
    tick();
    wr0 = 1'b0; wr1 = 1'b0;
    tick();
    check("t5_start", {31'd0, tx_start}, 1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 4) check("t5_err_early", {31'd0, err_timeout}, 0);
      if (i == 5) check("t5_err", {31'd0, err_timeout}, 1);
    end
    check("t5_pend1_kept", {31'd0, pend1}, 1);
    tick();
    check("t5_next_start", {31'd0, tx_start}, 1);
    check("t5_next_grant", {31'd0, grant_id}, 1);
    wait_idle("t5");
    check("t5_err_sticky", {31'd0, err_timeout}, 1);
    model_en = 1'b1;

    // T6: reset in WAIT_DONE with a byte pending
    do_reset();
    frame_len = 20;
    expq.push_back({1'b0, 8'h99});
    pulse0(8'h99);
    repeat (3) tick();
    pulse0(8'h66);
    check("t6_pend0", {31'd0, pend0}, 1);
    check("t6_busy", {31'd0, tx_busy}, 1);
    s0 = n_starts;
    do_reset();
    check("t6_rst_pend", {30'd0, pend1, pend0}, 0);
    check("t6_rst_out", {21'd0, tx_start, tx_data, grant_id, ovf1, ovf0}, 0);
    check("t6_rst_err", {31'd0, err_timeout}, 0);
    for (int k = 0; k < 100 && tx_busy; k++) tick();
    repeat (5) tick();
    check("t6_no_start", n_starts - s0, 0);
    expq.push_back({1'b0, 8'h5A});
    pulse0(8'h5A);
    wait_idle("t6");
    check("t6_restart", n_starts - s0, 1);

    check("final_queue_empty", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

endmodule
